// File: rtl/comparador_pkg.sv
// Shared types for the MSB-first serial comparator: FSM states, running decision,
// relational mode and the decision-to-Zout mapping.
package comparador_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    DecEq = 2'b00,
    DecGt = 2'b01,
    DecLt = 2'b10
  } decision_e;

  typedef enum logic [1:0] {
    ModeLe = 2'b00,
    ModeLt = 2'b01,
    ModeEq = 2'b10,
    ModeGe = 2'b11
  } mode_e;

  function automatic logic zout_f(input decision_e dec, input mode_e mode);
    logic z;
    z = 1'b0;
    case (mode)
      ModeLe:  z = (dec == DecLt) || (dec == DecEq);
      ModeLt:  z = (dec == DecLt);
      ModeEq:  z = (dec == DecEq);
      ModeGe:  z = (dec == DecGt) || (dec == DecEq);
      default: z = 1'b0;
    endcase
    return z;
  endfunction

endpackage

// File: rtl/celda_comparadora.sv
// Combinational K-bit digit cell: a resolved (GT/LT) decision passes through unchanged,
// an EQ decision is refined by unsigned comparison of the current digits.
module celda_comparadora
  import comparador_pkg::*;
#(
  parameter int unsigned K = 1
) (
  input  decision_e      dec_i,
  input  logic [K-1:0]   a_dig_i,
  input  logic [K-1:0]   b_dig_i,
  output decision_e      dec_o
);

  always_comb begin
    dec_o = dec_i;
    if (dec_i == DecEq) begin
      if (a_dig_i > b_dig_i) begin
        dec_o = DecGt;
      end else if (a_dig_i < b_dig_i) begin
        dec_o = DecLt;
      end
    end
  end

endmodule

// File: rtl/comparador_serial_izq_der.sv
// Serial MSB-first comparator scanning K bits per clock through one reusable cell.
// Define COMPARADOR_SALIDA_TEMPRANA_EN to finish as soon as the decision is resolved.
module comparador_serial_izq_der
  import comparador_pkg::*;
#(
  parameter int unsigned N = 15,
  parameter int unsigned K = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic [1:0]   mode_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         zout_o,
  output logic         gt_o,
  output logic         eq_o
);

  localparam int unsigned D    = (N + K - 1) / K;
  localparam int unsigned W    = D * K;
  localparam int unsigned IdxW = (D > 1) ? $clog2(D) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(D - 1);

  state_e          state_q;
  logic [W-1:0]    a_q, b_q;
  mode_e           mode_q;
  decision_e       dec_q, dec_d;
  logic [IdxW-1:0] idx_q;
  logic            busy_q, done_q, zout_q, gt_q, eq_q;
  logic            fin;

  // Operands shift left each RUN cycle, so the current digit is always the top K bits.
  celda_comparadora #(
    .K(K)
  ) u_celda (
    .dec_i  (dec_q),
    .a_dig_i(a_q[W-1 -: K]),
    .b_dig_i(b_q[W-1 -: K]),
    .dec_o  (dec_d)
  );

`ifdef COMPARADOR_SALIDA_TEMPRANA_EN
  assign fin = (idx_q == '0) || (dec_d != DecEq);
`else
  assign fin = (idx_q == '0);
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= ModeLe;
      dec_q   <= DecEq;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      zout_q  <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            a_q     <= W'(a_i);
            b_q     <= W'(b_i);
            mode_q  <= mode_e'(mode_i);
            dec_q   <= DecEq;
            idx_q   <= IdxLast;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          dec_q <= dec_d;
          a_q   <= a_q << K;
          b_q   <= b_q << K;
          idx_q <= idx_q - IdxW'(1);
          if (fin) begin
            state_q <= StDone;
            done_q  <= 1'b1;
            zout_q  <= zout_f(dec_d, mode_q);
            gt_q    <= (dec_d == DecGt);
            eq_q    <= (dec_d == DecEq);
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign zout_o = zout_q;
  assign gt_o   = gt_q;
  assign eq_o   = eq_q;

endmodule

// File: tb/tb_comparador_serial_izq_der.sv
// Randomised and exhaustive checks of the serial comparator over several (N, K) builds
// against a relational-operator reference model.
module tb_comparador_serial_izq_der;

  localparam int NI = 6;
  localparam int NN[NI] = '{15, 15, 6, 6, 6, 15};
  localparam int KK[NI] = '{1, 4, 1, 2, 4, 15};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_r[NI];
  logic [1:0]  mode_r[NI];
  logic [14:0] a_r[NI];
  logic [14:0] b_r[NI];
  logic        busy_w[NI];
  logic        done_w[NI];
  logic        zout_w[NI];
  logic        gt_w[NI];
  logic        eq_w[NI];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  comparador_serial_izq_der #(.N(15), .K(1)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_r[0]), .mode_i(mode_r[0]),
    .a_i(a_r[0]), .b_i(b_r[0]), .busy_o(busy_w[0]), .done_o(done_w[0]),
    .zout_o(zout_w[0]), .gt_o(gt_w[0]), .eq_o(eq_w[0])
  );
  comparador_serial_izq_der #(.N(15), .K(4)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_r[1]), .mode_i(mode_r[1]),
    .a_i(a_r[1]), .b_i(b_r[1]), .busy_o(busy_w[1]), .done_o(done_w[1]),
    .zout_o(zout_w[1]), .gt_o(gt_w[1]), .eq_o(eq_w[1])
  );
  comparador_serial_izq_der #(.N(6), .K(1)) u2 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_r[2]), .mode_i(mode_r[2]),
    .a_i(a_r[2][5:0]), .b_i(b_r[2][5:0]), .busy_o(busy_w[2]), .done_o(done_w[2]),
    .zout_o(zout_w[2]), .gt_o(gt_w[2]), .eq_o(eq_w[2])
  );
  comparador_serial_izq_der #(.N(6), .K(2)) u3 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_r[3]), .mode_i(mode_r[3]),
    .a_i(a_r[3][5:0]), .b_i(b_r[3][5:0]), .busy_o(busy_w[3]), .done_o(done_w[3]),
    .zout_o(zout_w[3]), .gt_o(gt_w[3]), .eq_o(eq_w[3])
  );
  comparador_serial_izq_der #(.N(6), .K(4)) u4 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_r[4]), .mode_i(mode_r[4]),
    .a_i(a_r[4][5:0]), .b_i(b_r[4][5:0]), .busy_o(busy_w[4]), .done_o(done_w[4]),
    .zout_o(zout_w[4]), .gt_o(gt_w[4]), .eq_o(eq_w[4])
  );
  comparador_serial_izq_der #(.N(15), .K(15)) u5 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_r[5]), .mode_i(mode_r[5]),
    .a_i(a_r[5]), .b_i(b_r[5]), .busy_o(busy_w[5]), .done_o(done_w[5]),
    .zout_o(zout_w[5]), .gt_o(gt_w[5]), .eq_o(eq_w[5])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] mask_of(input int i);
    logic [14:0] m;
    m = 15'h7fff >> (15 - NN[i]);
    return m;
  endfunction

  function automatic int exp_lat(input int i, input logic [14:0] a, input logic [14:0] b);
    logic [14:0] x;
    int d;
    int hb;
    d  = (NN[i] + KK[i] - 1) / KK[i];
    x  = (a ^ b) & mask_of(i);
    hb = -1;
    for (int j = 0; j < 15; j++) if (x[j]) hb = j;
`ifdef COMPARADOR_SALIDA_TEMPRANA_EN
    if (hb >= 0) return d - hb / KK[i] + 1;
`endif
    return d + 1;
  endfunction

  function automatic logic exp_z(input int unsigned a, input int unsigned b, input logic [1:0] m);
    case (m)
      2'b00:   return a <= b;
      2'b01:   return a < b;
      2'b10:   return a == b;
      default: return a >= b;
    endcase
  endfunction

  // One request on every instance in act; with disturb, start and operands keep changing
  // while the instance is busy.
  task automatic go(input logic [NI-1:0] act, input logic [14:0] a, input logic [14:0] b,
                    input logic [1:0] m, input bit disturb);
    int   lat[NI];
    bit   seen[NI];
    logic z[NI], g[NI], e[NI];
    bit   pending;
    for (int i = 0; i < NI; i++) begin
      seen[i] = 1'b0;
      lat[i]  = 0;
      if (act[i]) begin
        a_r[i] = a; b_r[i] = b; mode_r[i] = m; start_r[i] = 1'b1;
      end
    end
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      pending = 1'b0;
      for (int i = 0; i < NI; i++) begin
        if (act[i] && !seen[i]) begin
          if (c == 1) chk($sformatf("u%0d busy_at_start", i), busy_w[i], 1);
          if (done_w[i]) begin
            seen[i] = 1'b1; lat[i] = c;
            z[i] = zout_w[i]; g[i] = gt_w[i]; e[i] = eq_w[i];
            start_r[i] = 1'b0;
          end else begin
            pending = 1'b1;
            start_r[i] = disturb;
            if (disturb) begin
              a_r[i] = 15'($urandom); b_r[i] = 15'($urandom); mode_r[i] = 2'($urandom);
            end
          end
        end
      end
      if (!pending) break;
    end
    for (int i = 0; i < NI; i++) begin
      if (act[i]) begin
        int unsigned ua, ub;
        ua = 32'(a & mask_of(i));
        ub = 32'(b & mask_of(i));
        chk($sformatf("u%0d done_seen", i), 32'(seen[i]), 1);
        chk($sformatf("u%0d latency a=%0h b=%0h", i, a, b), lat[i], exp_lat(i, a, b));
        chk($sformatf("u%0d zout a=%0h b=%0h m=%0d", i, a, b, m), 32'(z[i]), 32'(exp_z(ua, ub, m)));
        chk($sformatf("u%0d gt a=%0h b=%0h", i, a, b), 32'(g[i]), 32'(ua > ub));
        chk($sformatf("u%0d eq a=%0h b=%0h", i, a, b), 32'(e[i]), 32'(ua == ub));
      end
    end
    @(posedge clk); #1;
    for (int i = 0; i < NI; i++) begin
      if (act[i]) begin
        chk($sformatf("u%0d busy_after_done", i), busy_w[i], 0);
        chk($sformatf("u%0d done_pulse", i), done_w[i], 0);
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("u%0d %s busy", i, tag), busy_w[i], 0);
      chk($sformatf("u%0d %s done", i, tag), done_w[i], 0);
      chk($sformatf("u%0d %s zout", i, tag), zout_w[i], 0);
      chk($sformatf("u%0d %s gt", i, tag), gt_w[i], 0);
      chk($sformatf("u%0d %s eq", i, tag), eq_w[i], 0);
    end
  endtask

  initial begin
    logic [14:0] ra, rb;
    for (int i = 0; i < NI; i++) begin
      start_r[i] = 1'b0; mode_r[i] = 2'b00; a_r[i] = '0; b_r[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    go(6'b111111, 15'h7fff, 15'h7fff, 2'b00, 1'b0);
    go(6'b111111, 15'h7fff, 15'h7fff, 2'b01, 1'b0);
    go(6'b111111, 15'h7fff, 15'h0000, 2'b00, 1'b0);
    go(6'b111111, 15'h0001, 15'h0000, 2'b11, 1'b0);
    go(6'b111111, 15'h0000, 15'h0000, 2'b10, 1'b0);

    for (int a = 0; a < 64; a++) begin
      for (int b = 0; b < 64; b++) begin
        go(6'b011100, 15'(a), 15'(b), 2'((a + b) % 4), 1'b0);
      end
    end

    for (int t = 0; t < 200; t++) begin
      ra = 15'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : 15'($urandom);
      go(6'b100011, ra, rb, 2'($urandom), t[0]);
    end

    // Reset pulse in the middle of a run.
    for (int i = 0; i < NI; i++) begin
      a_r[i] = 15'h1234; b_r[i] = 15'h1234; mode_r[i] = 2'b10; start_r[i] = 1'b1;
    end
    @(posedge clk); #1;
    for (int i = 0; i < NI; i++) start_r[i] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1 chk_all_zero("mid_run_reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    go(6'b111111, 15'h0f0f, 15'h0f10, 2'b01, 1'b0);
    go(6'b111111, 15'h5555, 15'h5555, 2'b11, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
